// File: rtl/load_data_extract_reg.sv
// load_data_extract_reg
// MEM/WB pipeline register for loads. It takes the data-memory read word, the
// byte offset and the load type. It extracts and extends the byte, half or word,
// flags misaligned loads and registers the result for write-back. The w_*
// outputs are driven directly from flops, so the latency is one clock.

module load_data_extract_reg #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,       // asynchronous, active-low
    input  logic              stall,
    input  logic              flush,
    input  logic              m_valid,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_addr_lo,
    input  logic [2:0]        m_load_op,
    input  logic [REG_AW-1:0] m_rd,
    input  logic              m_regwrite,
    output logic              w_valid,
    output logic [31:0]       w_data,
    output logic [REG_AW-1:0] w_rd,
    output logic              w_regwrite,
    output logic              w_misalign
);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LW   = 3'd1,
        OP_LB   = 3'd2,
        OP_LBU  = 3'd3,
        OP_LH   = 3'd4,
        OP_LHU  = 3'd5
    } load_op_e;

    load_op_e    op;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;
    logic        misalign;
    logic        regwrite_next;

    // Encodings 6 and 7 have no enum member. They fall into the default arm below
    // and behave like NONE.
    assign op = load_op_e'(m_load_op);

    // Little-endian lane selection: choose the byte at the offset and the half
    // selected by offset bit 1.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default before the
        // case. A path that leaves one unassigned would infer a latch.
        byte_sel = m_rdata[7:0];
        unique case (m_addr_lo)
            2'd0: byte_sel = m_rdata[7:0];
            2'd1: byte_sel = m_rdata[15:8];
            2'd2: byte_sel = m_rdata[23:16];
            2'd3: byte_sel = m_rdata[31:24];
        endcase
        half_sel = m_addr_lo[1] ? m_rdata[31:16] : m_rdata[15:0];
    end

    // Extend the selected lane and detect misalignment. A misaligned load is
    // zeroed and never qualifies a register write.
    always_comb begin
        ext_data = m_rdata;
        misalign = 1'b0;
        case (op)
            OP_LW: begin
                ext_data = m_rdata;
                misalign = (m_addr_lo != 2'd0);
            end
            OP_LB:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: ext_data = {24'd0, byte_sel};
            OP_LH: begin
                ext_data = {{16{half_sel[15]}}, half_sel};
                misalign = m_addr_lo[0];
            end
            OP_LHU: begin
                ext_data = {16'd0, half_sel};
                misalign = m_addr_lo[0];
            end
            default: ext_data = m_rdata;
        endcase
        if (misalign) begin
            ext_data = 32'd0;
        end
        regwrite_next = m_valid & m_regwrite & ~misalign & (m_rd != '0);
    end

    // Stage register. Reset and flush load a bubble. Stall holds the stage.
    // Otherwise the stage captures the MEM inputs, or a bubble if m_valid is low.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop then
        // samples its pre-edge inputs, whatever order the statements are in.
        if (!reset) begin
            w_valid    <= 1'b0;
            w_data     <= 32'd0;
            w_rd       <= '0;
            w_regwrite <= 1'b0;
            w_misalign <= 1'b0;
        end else if (flush) begin
            w_valid    <= 1'b0;
            w_data     <= 32'd0;
            w_rd       <= '0;
            w_regwrite <= 1'b0;
            w_misalign <= 1'b0;
        end else if (!stall) begin
            if (m_valid) begin
                w_valid    <= 1'b1;
                w_data     <= ext_data;
                w_rd       <= m_rd;
                w_regwrite <= regwrite_next;
                w_misalign <= misalign;
            end else begin
                w_valid    <= 1'b0;
                w_data     <= 32'd0;
                w_rd       <= '0;
                w_regwrite <= 1'b0;
                w_misalign <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_data_extract_reg.sv
// Testbench for load_data_extract_reg. Directed steps push the expected stage
// contents into a scoreboard queue. The entry is popped and compared with the
// outputs one time unit after the capturing edge.

module tb_load_data_extract_reg;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        mis;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              flush;
    logic              m_valid;
    logic [31:0]       m_rdata;
    logic [1:0]        m_addr_lo;
    logic [2:0]        m_load_op;
    logic [REG_AW-1:0] m_rd;
    logic              m_regwrite;
    logic              w_valid;
    logic [31:0]       w_data;
    logic [REG_AW-1:0] w_rd;
    logic              w_regwrite;
    logic              w_misalign;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];

    localparam logic [2:0] NONE = 3'd0, LW = 3'd1, LB = 3'd2, LBU = 3'd3,
                           LH = 3'd4, LHU = 3'd5;

    load_data_extract_reg #(.REG_AW(REG_AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_rdata    (m_rdata),
        .m_addr_lo  (m_addr_lo),
        .m_load_op  (m_load_op),
        .m_rd       (m_rd),
        .m_regwrite (m_regwrite),
        .w_valid    (w_valid),
        .w_data     (w_data),
        .w_rd       (w_rd),
        .w_regwrite (w_regwrite),
        .w_misalign (w_misalign)
    );

    always #5 clk = ~clk;

    // Watchdog so that the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".valid"},    {31'd0, w_valid},    {31'd0, e.valid});
        check({tag, ".data"},     w_data,              e.data);
        check({tag, ".rd"},       {27'd0, w_rd},       {27'd0, e.rd});
        check({tag, ".regwrite"}, {31'd0, w_regwrite}, {31'd0, e.we});
        check({tag, ".misalign"}, {31'd0, w_misalign}, {31'd0, e.mis});
    endtask

    function automatic exp_t mk(input logic v, input logic [31:0] d, input logic [4:0] rd,
                                input logic we, input logic mis);
        exp_t e;
        e.valid = v; e.data = d; e.rd = rd; e.we = we; e.mis = mis;
        return e;
    endfunction

    // Drive one step on the falling edge and queue the expected result.
    // Compare after the next rising edge.
    task automatic step(input string tag, input logic v, input logic [31:0] d,
                        input logic [1:0] a, input logic [2:0] op, input logic [4:0] rd,
                        input logic rw, input logic st, input logic fl, input exp_t e);
        exp_t got;
        @(negedge clk);
        m_valid = v; m_rdata = d; m_addr_lo = a; m_load_op = op;
        m_rd = rd; m_regwrite = rw; stall = st; flush = fl;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb_q.pop_front();
            check_outputs(tag, got);
        end
    endtask

    initial begin
        exp_t zero;
        zero = mk(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);

        // Hold reset while the inputs toggle. The outputs must stay in the bubble state.
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        m_valid = 1'b1; m_rdata = 32'hDEADBEEF; m_addr_lo = 2'd0;
        m_load_op = LW; m_rd = 5'd7; m_regwrite = 1'b1;
        #1;
        check_outputs("reset_initial", zero);
        repeat (3) begin
            @(negedge clk);
            m_rdata = ~m_rdata; m_rd = m_rd + 5'd1; m_valid = ~m_valid;
        end
        #1;
        check_outputs("reset_held", zero);

        // Release reset on a falling edge. Nothing changes before the next rising edge.
        @(negedge clk);
        m_valid = 1'b1; m_rdata = 32'h12345678; m_addr_lo = 2'd0;
        m_load_op = LW; m_rd = 5'd5; m_regwrite = 1'b1;
        reset = 1'b1;
        #1;
        check_outputs("reset_release_hold", zero);
        @(posedge clk);
        #1;
        check_outputs("first_capture", mk(1'b1, 32'h12345678, 5'd5, 1'b1, 1'b0));

        // An asynchronous reset while stalled clears the stage at once.
        @(negedge clk);
        stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_outputs("reset_mid_stall", zero);
        @(negedge clk);
        stall = 1'b0;
        reset = 1'b1;

        // Byte loads at offsets 0..3.
        step("lb0",  1, 32'h80FF7F01, 2'd0, LB,  5'd3, 1, 0, 0, mk(1, 32'h00000001, 5'd3, 1, 0));
        step("lb1",  1, 32'h80FF7F01, 2'd1, LB,  5'd3, 1, 0, 0, mk(1, 32'h0000007F, 5'd3, 1, 0));
        step("lb2",  1, 32'h80FF7F01, 2'd2, LB,  5'd3, 1, 0, 0, mk(1, 32'hFFFFFFFF, 5'd3, 1, 0));
        step("lb3",  1, 32'h80FF7F01, 2'd3, LB,  5'd3, 1, 0, 0, mk(1, 32'hFFFFFF80, 5'd3, 1, 0));
        step("lbu0", 1, 32'h80FF7F01, 2'd0, LBU, 5'd4, 1, 0, 0, mk(1, 32'h00000001, 5'd4, 1, 0));
        step("lbu1", 1, 32'h80FF7F01, 2'd1, LBU, 5'd4, 1, 0, 0, mk(1, 32'h0000007F, 5'd4, 1, 0));
        step("lbu2", 1, 32'h80FF7F01, 2'd2, LBU, 5'd4, 1, 0, 0, mk(1, 32'h000000FF, 5'd4, 1, 0));
        step("lbu3", 1, 32'h80FF7F01, 2'd3, LBU, 5'd4, 1, 0, 0, mk(1, 32'h00000080, 5'd4, 1, 0));

        // Half loads. Half 0 = 7FFE, half 1 = 8001.
        step("lh0",  1, 32'h80017FFE, 2'd0, LH,  5'd6, 1, 0, 0, mk(1, 32'h00007FFE, 5'd6, 1, 0));
        step("lh2",  1, 32'h80017FFE, 2'd2, LH,  5'd6, 1, 0, 0, mk(1, 32'hFFFF8001, 5'd6, 1, 0));
        step("lhu0", 1, 32'h80017FFE, 2'd0, LHU, 5'd6, 1, 0, 0, mk(1, 32'h00007FFE, 5'd6, 1, 0));
        step("lhu2", 1, 32'h80017FFE, 2'd2, LHU, 5'd6, 1, 0, 0, mk(1, 32'h00008001, 5'd6, 1, 0));

        // Misaligned loads: data zeroed, write suppressed, rd kept.
        step("lw_mis1",  1, 32'hCAFEF00D, 2'd1, LW,  5'd9,  1, 0, 0, mk(1, 32'd0, 5'd9,  0, 1));
        step("lw_mis2",  1, 32'hCAFEF00D, 2'd2, LW,  5'd10, 1, 0, 0, mk(1, 32'd0, 5'd10, 0, 1));
        step("lh_mis1",  1, 32'hCAFEF00D, 2'd1, LH,  5'd11, 1, 0, 0, mk(1, 32'd0, 5'd11, 0, 1));
        step("lhu_mis3", 1, 32'hCAFEF00D, 2'd3, LHU, 5'd12, 1, 0, 0, mk(1, 32'd0, 5'd12, 0, 1));

        // Writes to x0 and writes with regwrite low are suppressed, and the data is still captured.
        step("lw_rd0",   1, 32'hA5A5A5A5, 2'd0, LW, 5'd0,  1, 0, 0, mk(1, 32'hA5A5A5A5, 5'd0,  0, 0));
        step("lw_nowe",  1, 32'h5A5A5A5A, 2'd0, LW, 5'd13, 0, 0, 0, mk(1, 32'h5A5A5A5A, 5'd13, 0, 0));

        // NONE and the unused encodings pass the word through at any offset.
        step("none3",    1, 32'h89ABCDEF, 2'd3, NONE, 5'd14, 1, 0, 0, mk(1, 32'h89ABCDEF, 5'd14, 1, 0));
        step("op6",      1, 32'h01020304, 2'd1, 3'd6, 5'd15, 1, 0, 0, mk(1, 32'h01020304, 5'd15, 1, 0));
        step("op7",      1, 32'hFEDCBA98, 2'd2, 3'd7, 5'd16, 1, 0, 0, mk(1, 32'hFEDCBA98, 5'd16, 1, 0));

        // An invalid instruction loads a bubble.
        step("invalid",  0, 32'hFFFFFFFF, 2'd0, LW, 5'd17, 1, 0, 0, zero);

        // Stall holds the stage against new inputs.
        step("pre_stall", 1, 32'h11223344, 2'd0, LW, 5'd18, 1, 0, 0, mk(1, 32'h11223344, 5'd18, 1, 0));
        step("stall1",    1, 32'h99999999, 2'd1, LB, 5'd19, 1, 1, 0, mk(1, 32'h11223344, 5'd18, 1, 0));
        step("stall2",    0, 32'h00000000, 2'd0, LW, 5'd20, 0, 1, 0, mk(1, 32'h11223344, 5'd18, 1, 0));

        // Flush wins over stall, and flush alone also loads a bubble.
        step("flush_stall", 1, 32'h77777777, 2'd0, LW, 5'd21, 1, 1, 1, zero);
        step("recapture",   1, 32'h0000FF80, 2'd0, LB, 5'd22, 1, 0, 0, mk(1, 32'hFFFFFF80, 5'd22, 1, 0));
        step("flush_only",  1, 32'h66666666, 2'd0, LW, 5'd23, 1, 0, 1, zero);

        // A reset while flushing leaves the bubble state.
        @(negedge clk);
        flush = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_outputs("reset_mid_flush", zero);
        @(negedge clk);
        flush = 1'b0;
        reset = 1'b1;
        step("after_reset", 1, 32'hBEEF0000, 2'd2, LHU, 5'd31, 1, 0, 0, mk(1, 32'h0000BEEF, 5'd31, 1, 0));

        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_drain: observed %0d leftover expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
